alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/def.sv | 29 ++
 rtl/alu.sv | 42 ++++
 rtl/alu_arb.sv | 154 +++++++++++++++
 tb/tb_alu_arb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/def.sv
// Shared definitions for the ALU arbiter slice: the integer funct3 opcode
// encoding, the per-requester ALU operation record and the requester count.
package def;

  localparam int ALU_ARB_N_REQ = 2;

  // funct3 encoding for integer register/immediate operations.
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } f3OpInt;

  // One ALU operation as presented by a requester.
  typedef struct packed {
    logic        op;
    logic        op_imm;
    f3OpInt      funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Shared integer ALU. op selects register-register form (funct7[5] turns ADD
// into SUB), op_imm the immediate form (no SUB). funct7[5] selects arithmetic
// right shift in both forms. With neither flag set the unit computes a + b.
module alu
  import def::*;
(
  input  logic        op,
  input  logic        op_imm,
  input  f3OpInt      funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [4:0] shamt_s;
  logic       unused_funct7_s;

  assign shamt_s         = b[4:0];
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  // Operation decode and result selection.
  always_comb begin
    result = a + b;
    if (op || op_imm) begin
      case (funct3)
        F3_ADD:  result = (op && funct7[5]) ? (a - b) : (a + b);
        F3_SLL:  result = a << shamt_s;
        F3_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
        F3_SLTU: result = {31'd0, (a < b)};
        F3_XOR:  result = a ^ b;
        F3_SR:   result = funct7[5] ? $unsigned($signed(a) >>> shamt_s) : (a >> shamt_s);
        F3_OR:   result = a | b;
        F3_AND:  result = a & b;
        default: result = a + b;
      endcase
    end else begin
      result = a + b;
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end to a single shared ALU. One stage register holds
// the accepted operation; its result is offered combinationally to the owner
// until consumed, and a new operation may be loaded in the same cycle.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins); default is round-robin.
module alu_arb
  import def::*;
#(
  parameter int N_REQ = ALU_ARB_N_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ-1:0]     req_op,
  input  logic [N_REQ-1:0]     req_op_imm,
  input  logic [3*N_REQ-1:0]   req_funct3,
  input  logic [7*N_REQ-1:0]   req_funct7,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_t
);

  logic       stage_valid_q, stage_valid_d;
  logic       owner_q, owner_d;
  alu_req_t   stage_q, stage_d;
  logic [1:0] grant_s;
  logic       release_s;
  logic       free_s;
  logic       accept_s;
  logic       sel_s;
  logic [31:0] alu_res_s;

  assign release_s = stage_valid_q & rsp_ready[owner_q];
  assign free_s    = ~stage_valid_q | release_s;
  assign accept_s  = |(req_valid & req_ready);
  assign sel_s     = req_ready[1];

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    grant_s = 2'b00;
    if (req_valid[0]) begin
      grant_s = 2'b01;
    end else if (req_valid[1]) begin
      grant_s = 2'b10;
    end else begin
      grant_s = 2'b00;
    end
  end
`else
  logic rr_q, rr_d;

  // Round-robin: on contention grant the requester not granted last.
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_q ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  // Last-granted pointer moves only when an operation is accepted.
  always_comb begin
    rr_d = rr_q;
    if (accept_s) begin
      rr_d = sel_s;
    end else begin
      rr_d = rr_q;
    end
  end

  // Pointer register; reset value 1 lets requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Ready only to the granted requester, and only when the stage can take it.
  always_comb begin
    req_ready = 2'b00;
    if (free_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Next stage contents: load on accept, drop on release, otherwise hold.
  always_comb begin
    stage_valid_d = stage_valid_q;
    owner_d       = owner_q;
    stage_d       = stage_q;
    if (accept_s) begin
      stage_valid_d  = 1'b1;
      owner_d        = sel_s;
      stage_d.op     = sel_s ? req_op[1]        : req_op[0];
      stage_d.op_imm = sel_s ? req_op_imm[1]    : req_op_imm[0];
      stage_d.funct3 = f3OpInt'(sel_s ? req_funct3[5:3] : req_funct3[2:0]);
      stage_d.funct7 = sel_s ? req_funct7[13:7] : req_funct7[6:0];
      stage_d.a      = sel_s ? req_a[63:32]     : req_a[31:0];
      stage_d.b      = sel_s ? req_b[63:32]     : req_b[31:0];
    end else if (release_s) begin
      stage_valid_d = 1'b0;
    end else begin
      stage_valid_d = stage_valid_q;
    end
  end

  // Stage register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      stage_q       <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      owner_q       <= owner_d;
      stage_q       <= stage_d;
    end
  end

  alu u_alu (
    .op     (stage_q.op),
    .op_imm (stage_q.op_imm),
    .funct3 (stage_q.funct3),
    .funct7 (stage_q.funct7),
    .a      (stage_q.a),
    .b      (stage_q.b),
    .result (alu_res_s)
  );

  // Response steering; result forced to zero while the stage is empty.
  always_comb begin
    rsp_valid = 2'b00;
    rsp_t     = 32'd0;
    if (stage_valid_q) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
      rsp_t     = alu_res_s;
    end else begin
      rsp_valid = 2'b00;
      rsp_t     = 32'd0;
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: single accept, stall/hold, non-owner ready,
// reset mid-operation, and arbitration (round-robin or fixed priority when
// ALU_ARB_FIXED_PRIO_EN is defined).
module tb_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_op, req_op_imm;
  logic [5:0]  req_funct3;
  logic [13:0] req_funct7;
  logic [63:0] req_a, req_b;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_t;

  int n_checks = 0;
  int n_err    = 0;

  alu_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_op_imm (req_op_imm),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_t      (rsp_t)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[i]            = 1'b1;
    req_op_imm[i]        = 1'b0;
    req_funct3[3*i +: 3] = f3;
    req_funct7[7*i +: 7] = f7;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_op     = 2'b00;
    req_op_imm = 2'b00;
    req_funct3 = 6'd0;
    req_funct7 = 14'd0;
    req_a      = 64'd0;
    req_b      = 64'd0;
    rsp_ready  = 2'b00;

    // Reset state
    #2;
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_t", rsp_t, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Single ADD from requester 0, latency one cycle
    set_req(0, 3'b000, 7'd0, 32'd20, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1 chk("add_req_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("add_rsp_t", rsp_t, 32'd27);
    chk("add_idle_ready", {30'd0, req_ready}, 32'd0);
    tick();
    chk("add_released", {30'd0, rsp_valid}, 32'd0);
    chk("empty_rsp_t", rsp_t, 32'd0);

    // Requester 1 SRA with stalled consumer; requester 0 waits with SRL
    set_req(1, 3'b101, 7'b0100000, 32'hFFFFFF9C, 32'd4);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1 chk("sra_req_ready", {30'd0, req_ready}, 32'd2);
    tick();
    set_req(0, 3'b101, 7'd0, 32'hFFFFFF9C, 32'd4);
    req_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      rsp_ready = (c == 1) ? 2'b01 : 2'b00;
      #1;
      chk("hold_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      chk("hold_rsp_t", rsp_t, 32'hFFFFFFF9);
      chk("hold_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    chk("resume_rsp_t", rsp_t, 32'hFFFFFFF9);
    chk("resume_req_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    chk("srl_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("srl_rsp_t", rsp_t, 32'h0FFFFFF9);

    // Reset mid-operation
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_t", rsp_t, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rsp_ready = 2'b11;
    tick();
    chk("postrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    tick();
    chk("postrst_rsp_valid2", {30'd0, rsp_valid}, 32'd0);

    // Both requesters contend: req0 SUB 20-7, req1 SLT -100<4
    set_req(0, 3'b000, 7'b0100000, 32'd20, 32'd7);
    set_req(1, 3'b010, 7'd0, 32'hFFFFFF9C, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1 chk("arb_first_ready", {30'd0, req_ready}, 32'd1);
    tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int c = 0; c < 4; c++) begin
      chk("fix_rsp_valid", {30'd0, rsp_valid}, 32'd1);
      chk("fix_rsp_t", rsp_t, 32'd13);
      chk("fix_req_ready", {30'd0, req_ready}, 32'd1);
      if (c == 3) req_valid = 2'b00;
      tick();
    end
`else
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) begin
        chk("rr_rsp_valid0", {30'd0, rsp_valid}, 32'd1);
        chk("rr_rsp_t0", rsp_t, 32'd13);
        chk("rr_req_ready0", {30'd0, req_ready}, 32'd2);
      end else begin
        chk("rr_rsp_valid1", {30'd0, rsp_valid}, 32'd2);
        chk("rr_rsp_t1", rsp_t, 32'd1);
        chk("rr_req_ready1", {30'd0, req_ready}, 32'd1);
      end
      if (c == 3) req_valid = 2'b00;
      tick();
    end
`endif
    chk("drain_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("drain_rsp_t", rsp_t, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
